// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter onto one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default: load-store wins.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                ls_req_i,
   input  logic                ls_we_i,
   input  logic [ADDR_W-1:0]   ls_addr_i,
   input  logic [DATA_W/8-1:0] ls_be_i,
   input  logic [DATA_W-1:0]   ls_wdata_i,
   output logic                ls_gnt_o,
   output logic                ls_rvalid_o,
   output logic [DATA_W-1:0]   ls_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                busy_o,
   output logic                owner_o
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t state_q, state_d;
   logic   owner_q;
   logic   any_req;
   logic   win_ls;
   logic   accept;
   logic   deliver;

   // Gating with reset keeps gnt quiet while reset is held low.
   assign any_req = (if_req_i | ls_req_i) & reset;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_ls_q;

   assign win_ls = ls_req_i & (~if_req_i | ~last_ls_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_ls_q <= 1'b1;
      else if (accept)
         last_ls_q <= win_ls;
   end
`else
   assign win_ls = ls_req_i;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      deliver = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_gnt_i) begin
               if (mem_rvalid_i) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               deliver = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q     <= win_ls;
            mem_we_o    <= win_ls & ls_we_i;
            mem_addr_o  <= win_ls ? ls_addr_i : if_addr_i;
            mem_be_o    <= win_ls ? ls_be_i : '1;
            mem_wdata_o <= win_ls ? ls_wdata_i : '0;
         end
      end
   end

   assign if_gnt_o    = accept & ~win_ls;
   assign ls_gnt_o    = accept & win_ls;
   assign if_rvalid_o = deliver & ~owner_q;
   assign ls_rvalid_o = deliver & owner_q;
   assign if_rdata_o  = mem_rdata_i;
   assign ls_rdata_o  = mem_rdata_i;
   assign mem_req_o   = (state_q == ISSUE);
   assign busy_o      = (state_q != IDLE);
   assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed cases.
// Build with ARB_ROUND_ROBIN_EN to check the alternating-priority variant.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i, ls_we_i;
   logic [31:0] ls_addr_i;
   logic [3:0]  ls_be_i;
   logic [31:0] ls_wdata_i;
   logic        ls_gnt_o, ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o, owner_o;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
      .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i),
      .ls_addr_i(ls_addr_i), .ls_be_i(ls_be_i),
      .ls_wdata_i(ls_wdata_i),
      .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
      .ls_rdata_o(ls_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   always #5 clk = ~clk;

   // Transaction-level view: is one open, has memory taken it, who owns it.
   typedef struct {
      bit          open;
      bit          taken;
      bit          owner;
      bit          we;
      bit          last_ls;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mstate_t;

   mstate_t m, n;
   int  checks = 0;
   int  errors = 0;
   bit  e_gif, e_gls, e_dlv;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
      end
   endtask

   function automatic mstate_t fresh();
      mstate_t s;
      s.open = 0; s.taken = 0; s.owner = 0; s.we = 0;
      s.last_ls = 1; s.addr = '0; s.wdata = '0; s.be = '0;
      return s;
   endfunction

   task automatic sample();
      bit wl;
      @(negedge clk);
      e_gif = 0; e_gls = 0; e_dlv = 0;
      n = m;
      if (!reset) begin
         n = fresh();
      end else if (!m.open) begin
         if (if_req_i || ls_req_i) begin
            wl = RR ? (ls_req_i && (!if_req_i || !m.last_ls)) : ls_req_i;
            e_gls = wl; e_gif = !wl;
            n.open = 1; n.taken = 0; n.owner = wl; n.last_ls = wl;
            n.we    = wl && ls_we_i;
            n.addr  = wl ? ls_addr_i : if_addr_i;
            n.be    = wl ? ls_be_i : 4'hF;
            n.wdata = wl ? ls_wdata_i : 32'h0;
         end
      end else begin
         e_dlv = mem_rvalid_i && (m.taken || mem_gnt_i);
         if (e_dlv) begin
            n.open = 0; n.taken = 0;
         end else if (!m.taken && mem_gnt_i) begin
            n.taken = 1;
         end
      end
      chk("if_gnt", if_gnt_o, e_gif);
      chk("ls_gnt", ls_gnt_o, e_gls);
      chk("if_rvalid", if_rvalid_o, e_dlv && !m.owner);
      chk("ls_rvalid", ls_rvalid_o, e_dlv && m.owner);
      chk("if_rdata", if_rdata_o, mem_rdata_i);
      chk("ls_rdata", ls_rdata_o, mem_rdata_i);
      chk("mem_req", mem_req_o, m.open && !m.taken);
      chk("mem_we", mem_we_o, m.we);
      chk("mem_addr", mem_addr_o, m.addr);
      chk("mem_be", mem_be_o, m.be);
      chk("mem_wdata", mem_wdata_o, m.wdata);
      chk("busy", busy_o, m.open);
      chk("owner", owner_o, m.owner);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      m = n;
   endtask

   task automatic idle_inputs();
      if_req_i = 0; if_addr_i = '0;
      ls_req_i = 0; ls_we_i = 0; ls_addr_i = '0;
      ls_be_i = '0; ls_wdata_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   task automatic do_reset();
      reset = 0;
      m = fresh();
      idle_inputs();
      sample();
      advance();
      reset = 1;
   endtask

   logic [3:0] exp_own;

   initial begin
      reset = 0;
      m = fresh();
      n = m;
      idle_inputs();
      do_reset();

      // Fetch with memory gnt, then rvalid one cycle later.
      if_req_i = 1; if_addr_i = 32'h10;
      sample(); chk("d033_gnt", if_gnt_o, 1'b1);
      advance();
      if_req_i = 0; mem_gnt_i = 1;
      sample(); chk("d033_addr", mem_addr_o, 32'h10);
      advance();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
      sample();
      chk("d033_rv", if_rvalid_o, 1'b1);
      chk("d033_rd", if_rdata_o, 32'h13);
      chk("d033_lsrv", ls_rvalid_o, 1'b0);
      advance();
      mem_rvalid_i = 0;

      // Store with gnt and rvalid together.
      ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h100;
      ls_be_i = 4'b0011; ls_wdata_i = 32'hDEADBEEF;
      sample(); chk("d034_gnt", ls_gnt_o, 1'b1);
      advance();
      ls_req_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1;
      sample();
      chk("d034_we", mem_we_o, 1'b1);
      chk("d034_be", mem_be_o, 4'b0011);
      chk("d034_rv", ls_rvalid_o, 1'b1);
      advance();
      mem_gnt_i = 0; mem_rvalid_i = 0;
      sample(); chk("d034_idle", busy_o, 1'b0);
      advance();

      // Constant contention, four back-to-back transactions.
      do_reset();
      exp_own = RR ? 4'b1010 : 4'b1111;
      if_req_i = 1; ls_req_i = 1; ls_we_i = 0;
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
      for (int k = 0; k < 4; k++) begin
         sample(); chk("d035_owner", ls_gnt_o, exp_own[k]);
         advance();
         sample();
         advance();
      end
      idle_inputs();

      // Memory stall for five cycles while the other port waits.
      do_reset();
      if_req_i = 1; if_addr_i = 32'h44;
      sample(); advance();
      if_req_i = 0; ls_req_i = 1; ls_addr_i = 32'h88;
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("d036_req", mem_req_o, 1'b1);
         chk("d036_addr", mem_addr_o, 32'h44);
         chk("d036_nognt", {if_gnt_o, ls_gnt_o}, 2'b00);
         advance();
      end
      mem_gnt_i = 1; mem_rvalid_i = 1;
      sample(); advance();
      mem_gnt_i = 0; mem_rvalid_i = 0;
      sample(); chk("d036_lsgnt", ls_gnt_o, 1'b1);
      advance();
      ls_req_i = 0;

      // Reset while waiting, then a stale rvalid.
      do_reset();
      if_req_i = 1; if_addr_i = 32'h20;
      sample(); advance();
      if_req_i = 0; mem_gnt_i = 1;
      sample(); advance();
      mem_gnt_i = 0;
      sample(); chk("d037_wait", busy_o, 1'b1);
      advance();
      reset = 0; m = fresh();
      sample();
      chk("d037_busy", busy_o, 1'b0);
      chk("d037_req", mem_req_o, 1'b0);
      chk("d037_addr", mem_addr_o, 32'h0);
      advance();
      reset = 1; mem_rvalid_i = 1;
      sample();
      chk("d037_rv", {if_rvalid_o, ls_rvalid_o}, 2'b00);
      advance();
      mem_rvalid_i = 0; ls_req_i = 1; ls_addr_i = 32'h200;
      sample(); chk("d037_gnt", ls_gnt_o, 1'b1);
      advance();
      ls_req_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1;
      sample(); advance();

      // Stray rvalid while idle.
      idle_inputs();
      mem_rvalid_i = 1;
      sample();
      chk("d038_rv", {if_rvalid_o, ls_rvalid_o}, 2'b00);
      advance();
      mem_rvalid_i = 0;
      sample(); chk("d038_idle", busy_o, 1'b0);
      advance();

      // Randomised traffic; requests are held until granted.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            if (!if_req_i || e_gif) begin
               if_req_i  = ($urandom_range(0, 2) != 0);
               if_addr_i = $urandom;
            end
            if (!ls_req_i || e_gls) begin
               ls_req_i   = ($urandom_range(0, 2) != 0);
               ls_we_i    = $urandom_range(0, 1);
               ls_addr_i  = $urandom;
               ls_be_i    = 4'($urandom);
               ls_wdata_i = $urandom;
            end
            mem_gnt_i    = $urandom_range(0, 1);
            mem_rvalid_i = $urandom_range(0, 1);
            mem_rdata_i  = $urandom;
            sample();
            advance();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
